// File: rtl/stack_ctrl_if.sv
// Bus bundle between the CPU/RAM side and stack_ctrl: push/pop strobes,
// RAM address/data/strobe and the pop result and status outputs.
interface stack_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  logic          push;
  logic          pop;
  logic [DW-1:0] din;
  logic          clear_err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  modport slave (
    input  push, pop, din, clear_err, ram_rdata,
    output ram_addr, ram_wdata, ram_we, pop_data, pop_valid,
           count, empty, full, overflow, underflow
  );

  modport master (
    output push, pop, din, clear_err, ram_rdata,
    input  ram_addr, ram_wdata, ram_we, pop_data, pop_valid,
           count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack-pointer controller in front of a 32x8 async-read RAM: maps push/pop
// strobes onto RAM address/write-enable and returns popped bytes registered.
module stack_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  stack_ctrl_if.slave  bus
);

  localparam logic [1:0]    OP_IDLE    = 2'b00;
  localparam logic [1:0]    OP_POP     = 2'b01;
  localparam logic [1:0]    OP_PUSH    = 2'b10;
  localparam logic [1:0]    OP_REPLACE = 2'b11;
  localparam logic [AW:0]   SP_ONE     = (AW+1)'(1);
  localparam logic [AW:0]   SP_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ADDR_ONE   = AW'(1);

  logic [AW:0]   sp_q, sp_d;
  logic [DW-1:0] pop_data_q, pop_data_d;
  logic          pop_valid_q, pop_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          empty_s;
  logic          full_s;
  logic [AW-1:0] top_addr_s;
  logic [AW-1:0] ram_addr_s;
  logic          ram_we_s;
  logic          ovf_set_s;
  logic          unf_set_s;

  assign empty_s    = (sp_q == {(AW+1){1'b0}});
  assign full_s     = (sp_q == SP_DEPTH);
  // Only consulted while sp > 0, so the modular wrap at sp == 0 never reaches the RAM.
  assign top_addr_s = sp_q[AW-1:0] - ADDR_ONE;

  // Operation decode: RAM access, next stack pointer, pop result and error events.
  always_comb begin
    sp_d        = sp_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    ram_we_s    = 1'b0;
    ram_addr_s  = empty_s ? {AW{1'b0}} : top_addr_s;

    case ({bus.push, bus.pop})
      OP_PUSH: begin
        if (!full_s) begin
          ram_addr_s = sp_q[AW-1:0];
          ram_we_s   = 1'b1;
          sp_d       = sp_q + SP_ONE;
        end else begin
          ovf_set_s  = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty_s) begin
          ram_addr_s  = top_addr_s;
          pop_data_d  = bus.ram_rdata;
          pop_valid_d = 1'b1;
          sp_d        = sp_q - SP_ONE;
        end else begin
          unf_set_s   = 1'b1;
        end
      end
      OP_REPLACE: begin
        // Old top is read combinationally before the write lands at the edge.
        if (!empty_s) begin
          ram_addr_s  = top_addr_s;
          ram_we_s    = 1'b1;
          pop_data_d  = bus.ram_rdata;
          pop_valid_d = 1'b1;
        end else begin
          ram_addr_s  = {AW{1'b0}};
          ram_we_s    = 1'b1;
          sp_d        = SP_ONE;
          unf_set_s   = 1'b1;
        end
      end
      OP_IDLE: begin
        pop_valid_d = 1'b0;
      end
      default: begin
        pop_valid_d = 1'b0;
      end
    endcase

    overflow_d  = ovf_set_s | (overflow_q  & ~bus.clear_err);
    underflow_d = unf_set_s | (underflow_q & ~bus.clear_err);
  end

  // State registers with synchronous reset taking priority over every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q        <= {(AW+1){1'b0}};
      pop_data_q  <= {DW{1'b0}};
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // A reset landing mid-stream must never write the RAM.
  assign bus.ram_we    = rst ? 1'b0 : ram_we_s;
  assign bus.ram_addr  = ram_addr_s;
  assign bus.ram_wdata = bus.din;
  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.count     = sp_q;
  assign bus.empty     = empty_s;
  assign bus.full      = full_s;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed vector table, corner sequences
// and randomized traffic against a queue-based stack model plus a RAM model.
module tb_stack_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stack_ctrl_if #(.DW(8), .AW(5)) bus ();

  stack_ctrl #(.DW(8), .AW(5), .DEPTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 32x8 RAM: asynchronous read, write at the rising edge
  logic [7:0] mem [32];
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the stack as a queue of bytes
  logic [7:0] m_stk[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_pv  = 1'b0;
  logic [7:0] m_pd  = 8'h00;
  logic       seen_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input logic ps, input logic pp, input logic [7:0] d,
                             input logic clr, input logic rs);
    int         n;
    logic       e_we;
    logic       a_chk;
    logic [4:0] e_addr;
    logic       ovf_set, unf_set;
    @(negedge clk);
    bus.push = ps; bus.pop = pp; bus.din = d; bus.clear_err = clr; rst = rs;
    n = m_stk.size();
    e_we = 1'b0; a_chk = 1'b0; e_addr = 5'd0; ovf_set = 1'b0; unf_set = 1'b0;
    if (!rs) begin
      if (ps && pp) begin
        e_we = 1'b1; a_chk = 1'b1;
        e_addr = (n > 0) ? 5'(n - 1) : 5'd0;
      end else if (ps) begin
        e_we = (n < 32); a_chk = (n < 32); e_addr = 5'(n);
      end else begin
        a_chk = 1'b1; e_addr = (n > 0) ? 5'(n - 1) : 5'd0;
      end
    end
    #1;
    seen_we = bus.ram_we;
    chk("ram_we", {31'd0, bus.ram_we}, {31'd0, e_we});
    chk("ram_wdata", {24'd0, bus.ram_wdata}, {24'd0, d});
    if (a_chk) chk("ram_addr", {27'd0, bus.ram_addr}, {27'd0, e_addr});
    // advance the model by one clock according to the stack rules
    if (rs) begin
      m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_pv = 1'b0; m_pd = 8'h00;
    end else begin
      m_pv = 1'b0;
      if (ps && pp) begin
        if (n > 0) begin
          m_pd = m_stk[n-1]; m_pv = 1'b1; m_stk[n-1] = d;
        end else begin
          m_stk.push_back(d); unf_set = 1'b1;
        end
      end else if (ps) begin
        if (n < 32) m_stk.push_back(d);
        else ovf_set = 1'b1;
      end else if (pp) begin
        if (n > 0) begin
          m_pd = m_stk.pop_back(); m_pv = 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
      m_ovf = ovf_set | (m_ovf & ~clr);
      m_unf = unf_set | (m_unf & ~clr);
    end
    @(posedge clk);
    #1;
    chk("count", {26'd0, bus.count}, 32'(m_stk.size()));
    chk("empty", {31'd0, bus.empty}, {31'd0, (m_stk.size() == 0)});
    chk("full", {31'd0, bus.full}, {31'd0, (m_stk.size() == 32)});
    chk("pop_valid", {31'd0, bus.pop_valid}, {31'd0, m_pv});
    chk("pop_data", {24'd0, bus.pop_data}, {24'd0, m_pd});
    chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
    chk("underflow", {31'd0, bus.underflow}, {31'd0, m_unf});
  endtask

  typedef struct {
    logic       push, pop;
    logic [7:0] din;
    logic       clr, rs;
    logic       e_we;
    logic [5:0] e_count;
    logic       e_pv;
    logic [7:0] e_pd;
    logic       e_ovf, e_unf;
  } vec_t;

  function automatic vec_t mk(logic ps, logic pp, logic [7:0] d, logic clr, logic rs,
                              logic we, logic [5:0] c, logic pv, logic [7:0] pd,
                              logic ovf, logic unf);
    vec_t v;
    v.push = ps; v.pop = pp; v.din = d; v.clr = clr; v.rs = rs;
    v.e_we = we; v.e_count = c; v.e_pv = pv; v.e_pd = pd; v.e_ovf = ovf; v.e_unf = unf;
    return v;
  endfunction

  vec_t vt [20];

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.din = 8'h00; bus.clear_err = 1'b0;

    //          push  pop   din    clr   rst   we    cnt   pv    pd     ovf   unf
    vt[0]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[1]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[2]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[3]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[4]  = mk(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[5]  = mk(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[6]  = mk(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[7]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 6'd2, 1'b1, 8'h33, 1'b0, 1'b0);
    vt[8]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 6'd1, 1'b1, 8'h22, 1'b0, 1'b0);
    vt[9]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 8'h11, 1'b0, 1'b0);
    vt[10] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h11, 1'b0, 1'b0);
    vt[11] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h11, 1'b0, 1'b1);
    vt[12] = mk(1'b1, 1'b1, 8'h5C, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 8'h11, 1'b0, 1'b1);
    vt[13] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 6'd1, 1'b0, 8'h11, 1'b0, 1'b0);
    vt[14] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 8'h5C, 1'b0, 1'b0);
    vt[15] = mk(1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 8'h5C, 1'b0, 1'b0);
    vt[16] = mk(1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 8'h5C, 1'b0, 1'b0);
    vt[17] = mk(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 6'd2, 1'b1, 8'h20, 1'b0, 1'b0);
    vt[18] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 6'd1, 1'b1, 8'h99, 1'b0, 1'b0);
    vt[19] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 8'h10, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      drive_cycle(vt[i].push, vt[i].pop, vt[i].din, vt[i].clr, vt[i].rs);
      chk("tbl_we", {31'd0, seen_we}, {31'd0, vt[i].e_we});
      chk("tbl_count", {26'd0, bus.count}, {26'd0, vt[i].e_count});
      chk("tbl_pop_valid", {31'd0, bus.pop_valid}, {31'd0, vt[i].e_pv});
      chk("tbl_pop_data", {24'd0, bus.pop_data}, {24'd0, vt[i].e_pd});
      chk("tbl_overflow", {31'd0, bus.overflow}, {31'd0, vt[i].e_ovf});
      chk("tbl_underflow", {31'd0, bus.underflow}, {31'd0, vt[i].e_unf});
    end

    // Fill to 32, replace while full, overflow, pop, clear
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) drive_cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    chk("fill_count", {26'd0, bus.count}, 32'd32);
    chk("fill_full", {31'd0, bus.full}, 32'd1);
    drive_cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    chk("full_repl_pd", {24'd0, bus.pop_data}, 32'h1F);
    chk("full_repl_cnt", {26'd0, bus.count}, 32'd32);
    chk("full_repl_ovf", {31'd0, bus.overflow}, 32'd0);
    drive_cycle(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    chk("ovf_no_write", {31'd0, seen_we}, 32'd0);
    chk("ovf_set", {31'd0, bus.overflow}, 32'd1);
    drive_cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("pop_after_full", {24'd0, bus.pop_data}, 32'h77);
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_cleared", {31'd0, bus.overflow}, 32'd0);

    // Reset in the same cycle as a push
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
    chk("rst_no_write", {31'd0, seen_we}, 32'd0);
    chk("rst_count", {26'd0, bus.count}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_pop_valid", {31'd0, bus.pop_valid}, 32'd0);

    // New error in the same cycle as clear_err: set wins
    drive_cycle(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("set_wins_unf", {31'd0, bus.underflow}, 32'd1);

    // Randomized traffic, alternating push-heavy and pop-heavy windows
    for (int i = 0; i < 3000; i++) begin
      int  r;
      logic ps, pp;
      r  = int'($urandom_range(0, 99));
      if (((i / 200) % 2) == 0) begin
        ps = (r < 70); pp = (r >= 55);
      end else begin
        ps = (r < 30); pp = (r >= 15);
      end
      drive_cycle(ps, pp, 8'($urandom), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Stack-pointer controller directly upstream of the 32x8 asynchronous-read data RAM. Turns CPU push/pop strobes into RAM address, write-data and write-enable.
- Consumes the RAM's combinational read data to return popped bytes.
- Keeps occupancy count, full/empty status and sticky overflow/underflow error flags.
- The stack grows upward from address 0.

Parameters:
- DW, 8, data width (must match RAM data width)
- AW, 5, RAM address width
- DEPTH, 32, stack entries (must equal 2**AW)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- push  input  1  push request, sampled each rising edge
- pop  input  1  pop request, sampled each rising edge
- din  input  DW  byte to push
- clear_err  input  1  clears sticky error flags
- ram_addr  output  AW  address to RAM (combinational)
- ram_wdata  output  DW  write data to RAM (combinational, equals din)
- ram_we  output  1  write enable to RAM (combinational)
- ram_rdata  input  DW  RAM asynchronous read data for ram_addr
- pop_data  output  DW  registered popped byte
- pop_valid  output  1  one-cycle pulse, pop_data updated
- count  output  AW+1  entries held, 0..DEPTH
- empty  output  1  count==0
- full  output  1  count==DEPTH
- overflow  output  1  sticky, push refused while full
- underflow  output  1  sticky, pop refused while empty

Behaviour:
- State: sp register (AW+1 bits, equals count); pop_data, pop_valid, overflow, underflow registers. No other state.
- Reset (rst high at rising edge):
  - sp=0, pop_data=0, pop_valid=0, overflow=0, underflow=0.
  - Reset has priority over all requests.
  - While rst is high, ram_we is forced 0, so a reset asserted mid-stream never writes RAM.
- empty and full decode combinationally from sp. After reset: empty=1, full=0, count=0.
- Operation decode, per cycle:
  - push only, not full: ram_addr=sp[AW-1:0], ram_we=1. RAM writes din at the edge; sp increments.
  - push only, full: ram_we=0, sp unchanged, overflow set.
  - pop only, not empty: ram_addr=sp-1. At the edge pop_data<=ram_rdata, pop_valid<=1, sp decrements.
  - pop only, empty: ram_we=0, sp unchanged, underflow set, pop_valid<=0.
  - push and pop, not empty (includes full): replace top.
    - ram_addr=sp-1, ram_we=1.
    - pop_data<=ram_rdata (the old top, valid because the RAM read is asynchronous and the write lands at the edge). pop_valid<=1.
    - RAM gets din; sp unchanged; no error flag.
  - push and pop, empty: push performed (address 0, sp becomes 1); underflow set; pop_valid<=0.
  - idle: ram_addr=sp-1 when not empty, else 0; ram_we=0; pop_valid<=0.
- Latency:
  - Push is visible in count the cycle after the edge.
  - Popped byte appears on pop_data with pop_valid high for exactly the one cycle after the pop edge.
  - pop_data holds its value otherwise.
- Error flags:
  - overflow/underflow stay set until clear_err or rst.
  - If clear_err is high in the same cycle a new error occurs, the flag ends set (set wins).
- Address wrap: sp never exceeds DEPTH. The sp-1 computation is only used when sp>0, so the address never wraps.
- ram_wdata always equals din.

Test Plan:
- Reset then idle 3 cycles -> count=0, empty=1, full=0, pop_valid=0, overflow=0, underflow=0, ram_we=0 throughout.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 times -> ram_we high on push cycles at addresses 0,1,2; pop_data=0x33, 0x22, 0x11 each with a one-cycle pop_valid; count 3->0; empty=1.
- Push 32 bytes (0x00..0x1F), then push 0xAA -> full=1, count=32, no write on the 33rd cycle, overflow=1. Pop -> pop_data=0x1F. Pulse clear_err -> overflow=0.
- Pop while empty -> underflow=1, count stays 0, pop_valid=0. Push+pop while empty with din=0x5C -> count=1, underflow=1, later pop returns 0x5C.
- Stack holds 0x10, 0x20. Push+pop with din=0x99 -> pop_data=0x20 with pop_valid, count stays 2, next pop returns 0x99. Repeat while full -> same replace behaviour, overflow stays 0.
- Push 5 bytes, assert rst in the same cycle as a push of 0xEE -> ram_we=0 that cycle, count=0 and empty=1 next cycle, pop_valid=0.
